// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and helpers for the one-hot ring monitor
//
// Purpose: lock FSM state type plus width-agnostic ring helpers.
// Helpers work on a RING_MAX_W-bit container. Callers zero-extend their
// ring vector into it and pass the real ring width. Rings wider than
// RING_MAX_W are not supported.
package ring_pkg;

  localparam int RING_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } ring_state_e;

  // Rotate left by one within the low `width` bits, so the bit at width-1
  // wraps to bit 0. Bits at and above `width` are returned as zero.
  function automatic logic [RING_MAX_W-1:0] rotl_onehot(
    input logic [RING_MAX_W-1:0] x,
    input int                    width
  );
    logic [RING_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < RING_MAX_W; i++) begin
      if (i == width - 1) begin
        r[0] = x[i];
      end else if (i < width - 1) begin
        r[i+1] = x[i];
      end
    end
    return r;
  endfunction

  // True when exactly one bit is set.
  function automatic logic onehot_check(input logic [RING_MAX_W-1:0] x);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < RING_MAX_W; i++) begin
      if (x[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return seen && !multi;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// rtl/ring_onehot_enc.sv - combinational one-hot to binary index encoder
//
// Purpose: decode a one-hot ring vector to the index of its set bit.
// Ports:
//   ring_i   [WIDTH]  ring vector to decode
//   index_o  [IDX_W]  position of the set bit. Meaningless when valid_o=0.
//   valid_o           ring_i is exactly one-hot
module ring_onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] ring_i,
  output logic [IDX_W-1:0] index_o,
  output logic             valid_o
);

  always_comb begin
    index_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_i[i]) index_o = i[IDX_W-1:0];
    end
    valid_o = onehot_check(RING_MAX_W'(ring_i));
  end

endmodule

// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - one-hot rotating ring checker, slot decoder and lock monitor
//
// Purpose: sample a ring vector and check that each sample is one-hot and is
// one left-rotation of the previous sample. Decode the sample to an index,
// and count integrity errors seen while locked.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   ring_in      [WIDTH]  ring vector under observation
//   clr_err      synchronous clear of err_count (takes priority over increment)
//   index        [$clog2(WIDTH)]  hot-bit position of the current sample
//                (holds the last value when the sample is not one-hot)
//   index_valid  current sample is one-hot
//   locked       monitor is in the LOCKED state
//   err_pulse    one-cycle pulse per error detected while LOCKED
//   err_count    [ERR_W]  saturating LOCKED error count
module ring_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     index_valid,
  output logic                     locked,
  output logic                     err_pulse,
  output logic [ERR_W-1:0]         err_count
);

  localparam int IDX_W = $clog2(WIDTH);
  // good_cnt counts 0..LOCK_COUNT-1 and needs at least one bit.
  localparam int GW    = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;

  logic [WIDTH-1:0]      s_cur_q, s_prev_q;
  ring_state_e           state_q, state_d;
  logic [GW-1:0]         good_cnt_q, good_cnt_d;
  logic [IDX_W-1:0]      index_q;
  logic                  index_valid_q;
  logic                  locked_q;
  logic                  err_pulse_q;
  logic [ERR_W-1:0]      err_count_q, err_count_d;

  logic [IDX_W-1:0]      enc_idx;
  logic                  onehot;
  logic [RING_MAX_W-1:0] prev_rot;
  logic                  step_ok;
  logic                  err_d;

  ring_onehot_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .ring_i  (s_cur_q),
    .index_o (enc_idx),
    .valid_o (onehot)
  );

  always_comb begin
    prev_rot = rotl_onehot(RING_MAX_W'(s_prev_q), WIDTH);
    step_ok  = onehot && (s_cur_q == prev_rot[WIDTH-1:0]);
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        if (onehot) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ST_ACQUIRE: begin
        if (step_ok) begin
          if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
            state_d    = ST_LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 1'b1;
          end
        end else if (onehot) begin
          // A valid but out-of-sequence slot restarts the streak in place.
          good_cnt_d = '0;
        end else begin
          state_d    = ST_SEARCH;
          good_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (!step_ok) begin
          err_d      = 1'b1;
          good_cnt_d = '0;
          state_d    = onehot ? ST_ACQUIRE : ST_SEARCH;
        end
      end
      default: begin
        state_d    = ST_SEARCH;
        good_cnt_d = '0;
      end
    endcase
  end

  // Clear wins over a coincident error. The count pins at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = '0;
    end else if (err_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_cur_q       <= '0;
      s_prev_q      <= '0;
      state_q       <= ST_SEARCH;
      good_cnt_q    <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      s_cur_q       <= ring_in;
      s_prev_q      <= s_cur_q;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      if (onehot) index_q <= enc_idx;
      index_valid_q <= onehot;
      locked_q      <= (state_d == ST_LOCKED);
      err_pulse_q   <= err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign locked      = locked_q;
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_ring_monitor.sv
// tb/tb_ring_monitor.sv - self-checking bench for ring_monitor
module tb_ring_monitor;

  localparam int W  = 4;
  localparam int LC = 4;
  localparam int EW = 2;
  localparam int EMAX = (1 << EW) - 1;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  ring_in;
  logic          clr_err;
  logic [1:0]    index;
  logic          index_valid;
  logic          locked;
  logic          err_pulse;
  logic [EW-1:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;

  ring_monitor #(
    .WIDTH      (W),
    .LOCK_COUNT (LC),
    .ERR_W      (EW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ring_in     (ring_in),
    .clr_err     (clr_err),
    .index       (index),
    .index_valid (index_valid),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] rot(input logic [W-1:0] x);
    int v;
    v = int'(x);
    return W'(((v << 1) | (v >> (W - 1))) & ((1 << W) - 1));
  endfunction

  function automatic int idx_of(input logic [W-1:0] x);
    for (int i = 0; i < W; i++) if (int'(x) == (1 << i)) return i;
    return -1;
  endfunction

  // Reference model: works on the sample history. run<0 means no one-hot
  // anchor yet; otherwise run is the number of correct rotations so far.
  logic [W-1:0] m_cur, m_prev;
  int           m_run;
  bit           m_locked;
  bit           m_oh, m_step, m_err;
  int           e_index;
  bit           e_valid, e_locked, e_pulse;
  int           e_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cur = '0; m_prev = '0; m_run = -1; m_locked = 0;
      e_index = 0; e_valid = 0; e_locked = 0; e_pulse = 0; e_cnt = 0;
    end else begin
      m_oh   = ($countones(m_cur) == 1);
      m_step = m_oh && (m_cur == rot(m_prev));
      m_err  = 0;
      if (m_locked) begin
        if (!m_step) begin
          m_err = 1; m_locked = 0; m_run = m_oh ? 0 : -1;
        end
      end else if (m_run < 0) begin
        m_run = m_oh ? 0 : -1;
      end else if (m_step) begin
        m_run++;
        if (m_run == LC) begin m_locked = 1; m_run = 0; end
      end else begin
        m_run = m_oh ? 0 : -1;
      end
      if (m_oh) e_index = idx_of(m_cur);
      e_valid  = m_oh;
      e_locked = m_locked;
      e_pulse  = m_err;
      if (clr_err) e_cnt = 0;
      else if (m_err && e_cnt < EMAX) e_cnt++;
      m_prev = m_cur;
      m_cur  = ring_in;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("m_index",       int'(index),       e_index);
      check("m_index_valid", int'(index_valid), int'(e_valid));
      check("m_locked",      int'(locked),      int'(e_locked));
      check("m_err_pulse",   int'(err_pulse),   int'(e_pulse));
      check("m_err_count",   int'(err_count),   e_cnt);
    end
  end

  logic [W-1:0] r;

  task automatic drive(input logic [W-1:0] v, input logic c);
    ring_in = v;
    clr_err = c;
    @(posedge clk);
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic run_good(input int n);
    repeat (n) begin
      r = rot(r);
      drive(r, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ring_in = '0;
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Clean ring from reset: edge k captures the k-th sample.
  task automatic clean_run(input string tag);
    for (int k = 1; k <= 10; k++) begin
      r = (k == 1) ? 4'b1000 : rot(r);
      drive(r, 1'b0);
      if (k == 2) begin
        check({tag, "_idx_e2"}, int'(index), 3);
        check({tag, "_valid_e2"}, int'(index_valid), 1);
      end
      if (k == 3) check({tag, "_idx_e3"}, int'(index), 0);
      if (k == 5) check({tag, "_locked_e5"}, int'(locked), 0);
      if (k == 6) check({tag, "_locked_e6"}, int'(locked), 1);
      if (k == 10) check({tag, "_errcnt"}, int'(err_count), 0);
    end
  endtask

  task automatic lock_err(input logic c, input int exp_cnt, input string tag);
    run_good(6);
    check({tag, "_pre_locked"}, int'(locked), 1);
    r = rot(rot(r));
    drive(r, 1'b0);
    r = rot(r);
    drive(r, c);
    check({tag, "_pulse"}, int'(err_pulse), 1);
    check({tag, "_count"}, int'(err_count), exp_cnt);
  endtask

  int hold_idx;
  int pick;

  initial begin
    reset_n = 1'b0;
    ring_in = '0;
    clr_err = 1'b0;
    r       = '0;
    #1;
    check("rst_index",  int'(index), 0);
    check("rst_valid",  int'(index_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_pulse",  int'(err_pulse), 0);
    check("rst_count",  int'(err_count), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    clean_run("clean");

    // Skip while locked.
    r = rot(rot(rot(r)));
    drive(r, 1'b0);
    r = rot(r);
    drive(r, 1'b0);
    check("skip_pulse",  int'(err_pulse), 1);
    check("skip_count",  int'(err_count), 1);
    check("skip_locked", int'(locked), 0);
    for (int j = 1; j <= 4; j++) begin
      run_good(1);
      if (j == 1) check("skip_pulse_off", int'(err_pulse), 0);
      if (j == 3) check("skip_relock_e3", int'(locked), 0);
      if (j == 4) check("skip_relock_e4", int'(locked), 1);
    end

    // Non-one-hot while locked: 0000 then 1100 produce a single error.
    hold_idx = idx_of(r);
    drive(4'b0000, 1'b0);
    drive(4'b1100, 1'b0);
    check("zero_pulse", int'(err_pulse), 1);
    check("zero_count", int'(err_count), 2);
    check("zero_valid", int'(index_valid), 0);
    check("zero_hold",  int'(index), hold_idx);
    r = 4'b0001;
    drive(r, 1'b0);
    check("multi_pulse", int'(err_pulse), 0);
    check("multi_count", int'(err_count), 2);
    check("multi_hold",  int'(index), hold_idx);
    run_good(4);
    check("nz_relock_pre", int'(locked), 0);
    run_good(1);
    check("nz_relock", int'(locked), 1);

    // Saturation, then clear colliding with an error.
    lock_err(1'b0, 3, "sat3");
    lock_err(1'b0, 3, "sat4");
    lock_err(1'b0, 3, "sat5");
    lock_err(1'b1, 0, "clr6");

    // Asynchronous reset while locked.
    run_good(6);
    check("pre_rst_locked", int'(locked), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_index",  int'(index), 0);
    check("arst_valid",  int'(index_valid), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_pulse",  int'(err_pulse), 0);
    check("arst_count",  int'(err_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    clean_run("relock");

    // Wrong one-hot step at good_cnt=2 while acquiring.
    do_reset();
    r = 4'b1000;
    drive(r, 1'b0);
    run_good(2);
    drive(r, 1'b0);
    run_good(1);
    check("acq_pulse",  int'(err_pulse), 0);
    check("acq_locked", int'(locked), 0);
    run_good(3);
    check("acq_lock_pre", int'(locked), 0);
    run_good(1);
    check("acq_lock", int'(locked), 1);

    // Randomized traffic checked by the model every cycle.
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) do_reset();
      pick = int'($urandom_range(0, 99));
      if (pick < 85)      r = rot(r);
      else if (pick < 90) r = W'(1 << $urandom_range(0, W - 1));
      else if (pick < 95) r = W'($urandom_range(0, (1 << W) - 1));
      drive(r, ($urandom_range(0, 99) < 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
